dsp_prod_accum: RTL

DSP_PROD_ACCUM -- requirements
Module: dsp_prod_accum

---
 rtl/dsp_accum_pkg.sv | 20 ++
 rtl/dsp_sat_clamp.sv | 29 ++
 rtl/dsp_prod_accum.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dsp_accum_pkg.sv
// Shared types and constants for the product accumulator.
package dsp_accum_pkg;

  // Default widths: 20x18 signed multiplier feeding a 48-bit accumulator,
  // saturated down to a 40-bit result.
  localparam int unsigned DefAccW = 48;
  localparam int unsigned DefOutW = 40;
  localparam int unsigned DefPW   = 38;

  // Saturation limits for the default result width.
  localparam logic signed [DefOutW-1:0] SatMaxDef = {1'b0, {(DefOutW-1){1'b1}}};
  localparam logic signed [DefOutW-1:0] SatMinDef = {1'b1, {(DefOutW-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

endpackage

// File: rtl/dsp_sat_clamp.sv
// Combinational clamp of a wide signed accumulator into a narrower signed result.
module dsp_sat_clamp
  import dsp_accum_pkg::*;
#(
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned OUT_W = DefOutW
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [OUT_W-1:0] sat_out,
  output logic                    sat
);

  localparam logic [OUT_W-1:0] OutMax = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OutMin = {1'b1, {(OUT_W-1){1'b0}}};

  // The value fits iff every bit from the result sign bit upward agrees.
  logic [ACC_W-OUT_W:0] top_bits;
  assign top_bits = acc_in[ACC_W-1:OUT_W-1];

  // Clamp toward the sign of the accumulator on overflow, else pass the low bits.
  always_comb begin
    sat     = !((&top_bits) || (~|top_bits));
    sat_out = acc_in[OUT_W-1:0];
    if (sat) begin
      sat_out = acc_in[ACC_W-1] ? OutMin : OutMax;
    end
  end

endmodule

// File: rtl/dsp_prod_accum.sv
// Accumulates len signed products into one saturated result with a
// valid/ready handshake on both sides.
module dsp_prod_accum
  import dsp_accum_pkg::*;
#(
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned P_W   = DefPW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    p_valid,
  output logic                    p_ready,
  input  logic signed [P_W-1:0]   P,
  input  logic [7:0]              len,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic signed [OUT_W-1:0] acc_out,
  output logic                    acc_sat
);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [7:0]               len_q, len_d;
  logic signed [OUT_W-1:0]  acc_out_q, acc_out_d;
  logic                     acc_sat_q, acc_sat_d;

  logic                     xfer;
  logic                     load_out;
  logic [7:0]               len_eff;
  logic signed [ACC_W-1:0]  p_ext;
  logic signed [OUT_W-1:0]  clamp_out;
  logic                     clamp_sat;

  assign p_ready   = (state_q != StHold);
  assign acc_valid = (state_q == StHold);
  assign acc_out   = acc_out_q;
  assign acc_sat   = acc_sat_q;

  assign xfer    = p_valid && p_ready;
  assign len_eff = (len == 8'd0) ? 8'd1 : len;
  assign p_ext   = {{(ACC_W-P_W){P[P_W-1]}}, P};

  // Clamp the next accumulator value so the result is ready when HOLD is entered.
  dsp_sat_clamp #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat_clamp (
    .acc_in  (acc_d),
    .sat_out (clamp_out),
    .sat     (clamp_sat)
  );

  // Next-state logic; clr overrides everything and drops any in-flight beat.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    load_out  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          len_d = len_eff;
          acc_d = p_ext;
          cnt_d = 8'd1;
          if (len_eff == 8'd1) begin
            state_d  = StHold;
            load_out = 1'b1;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (xfer) begin
          acc_d = acc_q + p_ext;
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == len_q) begin
            state_d  = StHold;
            load_out = 1'b1;
          end
        end
      end
      StHold: begin
        if (acc_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clr) begin
      state_d  = StIdle;
      acc_d    = '0;
      cnt_d    = '0;
      load_out = 1'b0;
    end
  end

  // Result registers only change on entry to HOLD, so they stay put under backpressure.
  always_comb begin
    acc_out_d = acc_out_q;
    acc_sat_d = acc_sat_q;
    if (load_out) begin
      acc_out_d = clamp_out;
      acc_sat_d = clamp_sat;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= 8'd1;
      acc_out_q <= '0;
      acc_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      acc_out_q <= acc_out_d;
      acc_sat_q <= acc_sat_d;
    end
  end

endmodule
